sha2_seq_ctrl: RTL and testbench

Sequencer in front of the shared combinational SHA-2 unit (sha2_unit) in the ibex-crypto datapath.
- Accepts one SHA-256 (32-bit) or SHA-512 (64-bit) sigma/sum request over a valid/ready handshake.
- Drives the unit for one or two passes, selecting the ibex_pkg::sha2_op_t code and operand order for each pass.
- Assembles the 64-bit result and holds it on a valid/ready response port.
- Only one request is in flight at a time.

---
 rtl/sha2_seq_ctrl_pkg.sv | 81 ++++++++
 rtl/sha2_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sha2_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_seq_ctrl_pkg.sv
// sha2_seq_ctrl_pkg
// Shared types and helpers for the SHA-2 request sequencer:
//   sha2_op_t         - operation codes understood by the combinational SHA-2 unit
//   sha2_seq_op_t     - request-level operation (SHA-256 single word / SHA-512 word pair)
//   sha2_seq_state_t  - sequencer FSM states
//   sha2_seq_is512    - request needs two unit passes
//   sha2_seq_pass_a_op / sha2_seq_pass_b_op - unit code for each pass of a request
`timescale 1ns/1ps

package sha2_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        SIG0,
        SIG1,
        SUM0,
        SUM1,
        SIG0H,
        SIG0L,
        SIG1H,
        SIG1L,
        SUM0R,
        SUM1R
    } sha2_op_t;

    typedef enum logic [2:0] {
        SIG0_256,
        SIG1_256,
        SUM0_256,
        SUM1_256,
        SIG0_512,
        SIG1_512,
        SUM0_512,
        SUM1_512
    } sha2_seq_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StPassA,
        StPassB,
        StResp,
        StWaitA,
        StWaitB
    } sha2_seq_state_t;

    function automatic logic sha2_seq_is512(input sha2_seq_op_t op);
        return op[2];
    endfunction

    // Pass A of a 512 op produces the high result word.
    function automatic sha2_op_t sha2_seq_pass_a_op(input sha2_seq_op_t op);
        sha2_op_t code;
        code = SIG0;
        case (op)
            SIG0_256: code = SIG0;
            SIG1_256: code = SIG1;
            SUM0_256: code = SUM0;
            SUM1_256: code = SUM1;
            SIG0_512: code = SIG0H;
            SIG1_512: code = SIG1H;
            SUM0_512: code = SUM0R;
            SUM1_512: code = SUM1R;
            default:  code = SIG0;
        endcase
        return code;
    endfunction

    // Pass B of a 512 op produces the low result word; 256 ops never run it.
    function automatic sha2_op_t sha2_seq_pass_b_op(input sha2_seq_op_t op);
        sha2_op_t code;
        code = SIG0;
        case (op)
            SIG0_512: code = SIG0L;
            SIG1_512: code = SIG1L;
            SUM0_512: code = SUM0R;
            SUM1_512: code = SUM1R;
            default:  code = sha2_seq_pass_a_op(op);
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sha2_seq_ctrl.sv
// sha2_seq_ctrl
// Sequences one SHA-256 or SHA-512 sigma/sum request at a time through the shared
// combinational SHA-2 unit and holds the 64-bit result on a valid/ready response port.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake; req_op_i, req_hi_i, req_lo_i payload
//   rsp_valid_o / rsp_ready_i    response handshake; rsp_hi_o, rsp_lo_o result
//   busy_o                       a request is in flight
//   sha2_en_o, sha2_op_o,
//   op_a_o, op_b_o               drive the SHA-2 unit
//   sha2_result_i                SHA-2 unit result
//
// Parameters:
//   ZERO_IDLE  1: operands forced to 0 when no pass runs; 0: last operands held.
//
// Build option:
//   SHA2_SEQ_RESULT_REG_EN  registers the unit result after each pass and inserts a
//                           WAIT state per pass (latency 3 / 5 instead of 2 / 3).
`timescale 1ns/1ps

module sha2_seq_ctrl
    import sha2_seq_ctrl_pkg::*;
#(
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  sha2_seq_op_t req_op_i,
    input  logic [31:0]  req_hi_i,
    input  logic [31:0]  req_lo_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [31:0]  rsp_hi_o,
    output logic [31:0]  rsp_lo_o,
    output logic         busy_o,
    output logic         sha2_en_o,
    output sha2_op_t     sha2_op_o,
    output logic [31:0]  op_a_o,
    output logic [31:0]  op_b_o,
    input  logic [31:0]  sha2_result_i
);

    sha2_seq_state_t r_state;
    sha2_seq_op_t    r_op;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_rsp_hi;
    logic [31:0]     r_rsp_lo;
    logic            r_en;
    sha2_op_t        r_sha2_op;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;

    logic            w_accept;
    logic [31:0]     w_pass_result;

`ifdef SHA2_SEQ_RESULT_REG_EN
    // Results are committed one cycle after each pass, from the staging register.
    localparam sha2_seq_state_t StEndA = StWaitA;
    localparam sha2_seq_state_t StEndB = StWaitB;

    logic [31:0] r_result;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else if (r_en) begin
            r_result <= sha2_result_i;
        end
    end

    assign w_pass_result = r_result;
`else
    localparam sha2_seq_state_t StEndA = StPassA;
    localparam sha2_seq_state_t StEndB = StPassB;

    assign w_pass_result = sha2_result_i;
`endif

    assign w_accept = req_valid_i && (r_state == StIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_op      <= SIG0_256;
            r_hi      <= '0;
            r_lo      <= '0;
            r_rsp_hi  <= '0;
            r_rsp_lo  <= '0;
            r_en      <= 1'b0;
            r_sha2_op <= SIG0;
            r_op_a    <= '0;
            r_op_b    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op      <= req_op_i;
                        r_hi      <= req_hi_i;
                        r_lo      <= req_lo_i;
                        r_state   <= StPassA;
                        r_en      <= 1'b1;
                        r_sha2_op <= sha2_seq_pass_a_op(req_op_i);
                        r_op_a    <= sha2_seq_is512(req_op_i) ? req_hi_i : req_lo_i;
                        r_op_b    <= sha2_seq_is512(req_op_i) ? req_lo_i : '0;
                    end
                end
`ifdef SHA2_SEQ_RESULT_REG_EN
                // Operands and op code stay put so the staged result matches them.
                StPassA: begin
                    r_en    <= 1'b0;
                    r_state <= StWaitA;
                end
                StPassB: begin
                    r_en    <= 1'b0;
                    r_state <= StWaitB;
                end
`endif
                StEndA: begin
                    if (sha2_seq_is512(r_op)) begin
                        r_rsp_hi  <= w_pass_result;
                        r_state   <= StPassB;
                        r_en      <= 1'b1;
                        r_sha2_op <= sha2_seq_pass_b_op(r_op);
                        r_op_a    <= r_lo;
                        r_op_b    <= r_hi;
                    end else begin
                        r_rsp_hi <= '0;
                        r_rsp_lo <= w_pass_result;
                        r_state  <= StResp;
                        r_en     <= 1'b0;
                        if (ZERO_IDLE) begin
                            r_op_a <= '0;
                            r_op_b <= '0;
                        end
                    end
                end
                StEndB: begin
                    r_rsp_lo <= w_pass_result;
                    r_state  <= StResp;
                    r_en     <= 1'b0;
                    if (ZERO_IDLE) begin
                        r_op_a <= '0;
                        r_op_b <= '0;
                    end
                end
                StResp: begin
                    // Back to IDLE only; the next accept waits one cycle.
                    if (rsp_ready_i) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == StIdle);
    assign busy_o      = (r_state != StIdle);
    assign rsp_valid_o = (r_state == StResp);
    assign rsp_hi_o    = r_rsp_hi;
    assign rsp_lo_o    = r_rsp_lo;
    assign sha2_en_o   = r_en;
    assign sha2_op_o   = r_sha2_op;
    assign op_a_o      = r_op_a;
    assign op_b_o      = r_op_b;

endmodule

// File: tb/tb_sha2_seq_ctrl.sv
// tb_sha2_seq_ctrl
// Directed bench for sha2_seq_ctrl with a behavioural SHA-2 unit attached and a
// 64-bit reference for the request-level results. Latency expectations follow
// SHA2_SEQ_RESULT_REG_EN when it is defined.
`timescale 1ns/1ps

module tb_sha2_seq_ctrl;
    import sha2_seq_ctrl_pkg::*;

`ifdef SHA2_SEQ_RESULT_REG_EN
    localparam int Lat256 = 3;
    localparam int Lat512 = 5;
`else
    localparam int Lat256 = 2;
    localparam int Lat512 = 3;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    sha2_seq_op_t req_op_i;
    logic [31:0]  req_hi_i;
    logic [31:0]  req_lo_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [31:0]  rsp_hi_o;
    logic [31:0]  rsp_lo_o;
    logic         busy_o;
    logic         sha2_en_o;
    sha2_op_t     sha2_op_o;
    logic [31:0]  op_a_o;
    logic [31:0]  op_b_o;
    logic [31:0]  sha2_result_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    sha2_seq_ctrl #(
        .ZERO_IDLE(1'b1)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_hi_i     (req_hi_i),
        .req_lo_i     (req_lo_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_hi_o     (rsp_hi_o),
        .rsp_lo_o     (rsp_lo_o),
        .busy_o       (busy_o),
        .sha2_en_o    (sha2_en_o),
        .sha2_op_o    (sha2_op_o),
        .op_a_o       (op_a_o),
        .op_b_o       (op_b_o),
        .sha2_result_i(sha2_result_i)
    );

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Behavioural SHA-2 unit (scalar-crypto instruction semantics).
    function automatic logic [31:0] unit_f(input logic en, input sha2_op_t op,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (en) begin
            case (op)
                SIG0:  r = ror32(a, 7) ^ ror32(a, 18) ^ (a >> 3);
                SIG1:  r = ror32(a, 17) ^ ror32(a, 19) ^ (a >> 10);
                SUM0:  r = ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22);
                SUM1:  r = ror32(a, 6) ^ ror32(a, 11) ^ ror32(a, 25);
                SIG0H: r = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 24);
                SIG0L: r = (a >> 1) ^ (a >> 7) ^ (a >> 8) ^ (b << 31) ^ (b << 25) ^ (b << 24);
                SIG1H: r = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 13);
                SIG1L: r = (a << 3) ^ (a >> 6) ^ (a >> 19) ^ (b >> 29) ^ (b << 26) ^ (b << 13);
                SUM0R: r = (a << 25) ^ (a << 30) ^ (a >> 28) ^ (b >> 7) ^ (b >> 2) ^ (b << 4);
                SUM1R: r = (a << 23) ^ (a >> 14) ^ (a >> 18) ^ (b >> 9) ^ (b << 18) ^ (b << 14);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign sha2_result_i = unit_f(sha2_en_o, sha2_op_o, op_a_o, op_b_o);

    // Full-width reference: SHA-256 functions on lo, SHA-512 functions on {hi, lo}.
    function automatic logic [63:0] ref_f(input sha2_seq_op_t op, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [63:0] x;
        logic [63:0] r;
        x = {hi, lo};
        r = '0;
        case (op)
            SIG0_256: r = {32'h0, ror32(lo, 7) ^ ror32(lo, 18) ^ (lo >> 3)};
            SIG1_256: r = {32'h0, ror32(lo, 17) ^ ror32(lo, 19) ^ (lo >> 10)};
            SUM0_256: r = {32'h0, ror32(lo, 2) ^ ror32(lo, 13) ^ ror32(lo, 22)};
            SUM1_256: r = {32'h0, ror32(lo, 6) ^ ror32(lo, 11) ^ ror32(lo, 25)};
            SIG0_512: r = ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
            SIG1_512: r = ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
            SUM0_512: r = ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
            SUM1_512: r = ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic sha2_op_t code_a_f(input sha2_seq_op_t op);
        case (op)
            SIG0_256: return SIG0;
            SIG1_256: return SIG1;
            SUM0_256: return SUM0;
            SUM1_256: return SUM1;
            SIG0_512: return SIG0H;
            SIG1_512: return SIG1H;
            SUM0_512: return SUM0R;
            default:  return SUM1R;
        endcase
    endfunction

    function automatic sha2_op_t code_b_f(input sha2_seq_op_t op);
        case (op)
            SIG0_512: return SIG0L;
            SIG1_512: return SIG1L;
            SUM0_512: return SUM0R;
            SUM1_512: return SUM1R;
            default:  return code_a_f(op);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE at a negedge, follow it through its passes, hold the
    // response for `hold` cycles, then consume it. Returns at the negedge after the
    // response handshake.
    task automatic do_op(input sha2_seq_op_t op, input logic [31:0] hi, input logic [31:0] lo,
                         input sha2_op_t code_a, input sha2_op_t code_b,
                         input logic [63:0] exp, input int hold);
        int lat;
        int passes;
        bit done;
        bit is512;
        logic [31:0] ea;
        logic [31:0] eb;
        is512 = (op == SIG0_512) || (op == SIG1_512) || (op == SUM0_512) || (op == SUM1_512);
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_hi_i    = hi;
        req_lo_i    = lo;
        lat    = 0;
        passes = 0;
        done   = 1'b0;
        while (!done && lat < 12) begin
            @(negedge clk_i);
            lat++;
            req_valid_i = 1'b0;
            if (sha2_en_o) begin
                if (!is512) begin
                    ea = lo;
                    eb = 32'h0;
                end else if (passes == 0) begin
                    ea = hi;
                    eb = lo;
                end else begin
                    ea = lo;
                    eb = hi;
                end
                chk("pass_code", 64'(sha2_op_o), 64'((passes == 0) ? code_a : code_b));
                chk("pass_ops", {op_a_o, op_b_o}, {ea, eb});
                chk("busy_pass", 64'(busy_o), 64'd1);
                passes++;
            end
            if (rsp_valid_o) done = 1'b1;
        end
        chk("latency", 64'(lat), 64'(is512 ? Lat512 : Lat256));
        chk("pass_count", 64'(passes), 64'(is512 ? 2 : 1));
        chk("rsp_data", {rsp_hi_o, rsp_lo_o}, exp);
        chk("idle_operands", {op_a_o, op_b_o}, 64'd0);
        chk("en_resp", 64'(sha2_en_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("rsp_hold_data", {rsp_hi_o, rsp_lo_o}, exp);
        end
        chk("req_ready_resp", 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("rsp_valid_after", 64'(rsp_valid_o), 64'd0);
        chk("req_ready_after", 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        int n;
        int passes;
        sha2_seq_op_t op;
        logic [31:0] h;
        logic [31:0] l;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = SIG0_256;
        req_hi_i    = 32'h0;
        req_lo_i    = 32'h0;
        rsp_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        chk("reset_req_ready", 64'(req_ready_o), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rsp_data", {rsp_hi_o, rsp_lo_o}, 64'd0);
        chk("reset_en", 64'(sha2_en_o), 64'd0);
        chk("reset_code", 64'(sha2_op_o), 64'(SIG0));
        chk("reset_operands", {op_a_o, op_b_o}, 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);

        // SHA-256: hi must be ignored, result hi must be zero.
        do_op(SIG0_256, 32'hFFFF_FFFF, 32'h1, SIG0, SIG0, 64'h0000_0000_0200_4000, 0);
        do_op(SUM0_256, 32'h0, 32'h1, SUM0, SUM0, 64'h0000_0000_4008_0400, 5);
        do_op(SIG1_256, 32'h0, 32'h1, SIG1, SIG1, 64'h0000_0000_0000_A000, 1);
        do_op(SUM1_256, 32'h0, 32'h1, SUM1, SUM1, 64'h0000_0000_0420_0080, 0);

        // SHA-512 word pairs.
        do_op(SUM0_512, 32'h0, 32'h1, SUM0R, SUM0R, 64'h0000_0010_4200_0000, 0);
        do_op(SIG0_512, 32'h0, 32'h1, SIG0H, SIG0L, 64'h8100_0000_0000_0000, 2);
        do_op(SIG1_512, 32'h0, 32'h1, SIG1H, SIG1L, 64'h0000_2000_0000_0008, 0);
        do_op(SUM1_512, 32'h0, 32'h1, SUM1R, SUM1R, 64'h0004_4000_0080_0000, 1);

        // Reset during the second pass of a 512 op drops it.
        req_valid_i = 1'b1;
        req_op_i    = SUM1_512;
        req_hi_i    = 32'h1234_5678;
        req_lo_i    = 32'h9ABC_DEF0;
        n      = 0;
        passes = 0;
        while (passes < 2 && n < 12) begin
            @(negedge clk_i);
            n++;
            req_valid_i = 1'b0;
            if (sha2_en_o) passes++;
        end
        chk("inflight_pass_b", 64'(passes), 64'd2);
        chk("inflight_code", 64'(sha2_op_o), 64'(SUM1R));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("midrst_en", 64'(sha2_en_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_rsp_data", {rsp_hi_o, rsp_lo_o}, 64'd0);
        do_op(SIG0_256, 32'h0, 32'h1, SIG0, SIG0, 64'h0000_0000_0200_4000, 0);

        // Back-to-back stream over all ops with random operands and backpressure.
        for (int i = 0; i < 16; i++) begin
            op = sha2_seq_op_t'(i % 8);
            h  = $urandom;
            l  = $urandom;
            do_op(op, h, l, code_a_f(op), code_b_f(op), ref_f(op, h, l),
                  int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
